// File: rtl/std_cache_bypass_arbiter.sv
// -----------------------------------------------------------------------------
// std_cache_pkg / std_cache_bypass_arbiter
//
// Purpose:
//   Shares the single uncached (bypass) port of the std-cache miss handler
//   between NR_PORTS cache clients. Round-robin arbitration picks one client,
//   its request is registered and issued downstream, and the grant / response
//   are routed back to that client only. At most one transaction is in flight.
//
// Ports:
//   clk_i         in   clock
//   rst_ni        in   asynchronous reset, active low
//   req_i         in   NR_PORTS x bypass_req_t, client requests (.req qualifies)
//   rsp_o         out  NR_PORTS x bypass_rsp_t, client gnt/valid/rdata
//   bypass_req_o  out  request to the miss-handler bypass port (registered)
//   bypass_rsp_i  in   response from the miss-handler bypass port
//   busy_o        out  high while a transaction is in flight
// -----------------------------------------------------------------------------
package std_cache_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [7:0]  be;
        logic [1:0]  size;
        logic [3:0]  id;
        logic [63:0] addr;
        logic [63:0] wdata;
    } bypass_req_t;

    typedef struct packed {
        logic        gnt;
        logic        valid;
        logic [63:0] rdata;
    } bypass_rsp_t;

endpackage

module std_cache_bypass_arbiter
    import std_cache_pkg::*;
#(
    parameter int unsigned NR_PORTS = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  bypass_req_t [NR_PORTS-1:0] req_i,
    output bypass_rsp_t [NR_PORTS-1:0] rsp_o,
    output bypass_req_t                bypass_req_o,
    input  bypass_rsp_t                bypass_rsp_i,
    output logic                       busy_o
);

    localparam int unsigned IDX_W = $clog2(NR_PORTS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_winner;
    bypass_req_t      r_req;

    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_pick_next;
    bypass_req_t      w_issue;

    // Round-robin search: first requesting port at or after r_rr_ptr.
    // rr_ptr and k are both below NR_PORTS, so one subtraction wraps.
    always_comb begin
        int unsigned      sum;
        logic [IDX_W-1:0] idx;
        w_found = 1'b0;
        w_pick  = '0;
        sum     = 0;
        idx     = '0;
        for (int unsigned k = 0; k < NR_PORTS; k++) begin
            sum = 32'(r_rr_ptr) + k;
            if (sum >= NR_PORTS) begin
                sum = sum - NR_PORTS;
            end
            idx = IDX_W'(sum);
            if (!w_found && req_i[idx].req) begin
                w_found = 1'b1;
                w_pick  = idx;
            end
        end
    end

    // Next pointer and the request copy that will be issued downstream.
    // The client's id field is replaced by the port index so the response
    // can be traced back to its origin.
    always_comb begin
        w_pick_next = (32'(w_pick) == NR_PORTS - 1) ? '0 : IDX_W'(w_pick + 1'b1);
        w_issue     = req_i[w_pick];
        w_issue.req = 1'b1;
        w_issue.id  = 4'(w_pick);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_winner <= '0;
            r_req    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_req    <= w_issue;
                        r_winner <= w_pick;
                        r_rr_ptr <= w_pick_next;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A valid without gnt is not ours yet and is ignored.
                    if (bypass_rsp_i.gnt) begin
                        r_req.req <= 1'b0;
                        r_state   <= bypass_rsp_i.valid ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bypass_rsp_i.valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // r_req.req is high exactly while in S_REQ, so the register drives the
    // port directly and fields stay stable until the grant.
    assign bypass_req_o = r_req;
    assign busy_o       = (r_state != S_IDLE);

    // Grant/valid are passed through combinationally to the winner only;
    // rdata is broadcast and only meaningful alongside valid.
    always_comb begin
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            rsp_o[i].gnt   = 1'b0;
            rsp_o[i].valid = 1'b0;
            rsp_o[i].rdata = bypass_rsp_i.rdata;
        end
        if (r_state == S_REQ && bypass_rsp_i.gnt) begin
            rsp_o[r_winner].gnt   = 1'b1;
            rsp_o[r_winner].valid = bypass_rsp_i.valid;
        end else if (r_state == S_WAIT && bypass_rsp_i.valid) begin
            rsp_o[r_winner].valid = 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(r_state == S_REQ && bypass_rsp_i.valid && !bypass_rsp_i.gnt))
            else $warning("bypass arbiter: downstream valid without gnt in REQ, ignored");
            assert (!(r_state == S_WAIT && bypass_rsp_i.gnt))
            else $warning("bypass arbiter: downstream gnt while waiting for response, ignored");
            assert (32'(r_winner) < NR_PORTS)
            else $error("bypass arbiter: winner index out of range");
        end
    end
`endif

endmodule

// File: tb/tb_std_cache_bypass_arbiter.sv
// -----------------------------------------------------------------------------
// tb_std_cache_bypass_arbiter
//
// Purpose:
//   Self-checking bench for std_cache_bypass_arbiter (NR_PORTS = 4). Single
//   transactions come from a vector table; round-robin streaming, pointer wrap,
//   protocol noise and reset mid-transaction are hand-written sequences.
//   Expected responses are queued when a request is driven and popped by a
//   monitor whenever any client sees valid.
// -----------------------------------------------------------------------------
module tb_std_cache_bypass_arbiter;
    import std_cache_pkg::*;

    localparam int NP = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    bypass_req_t [NP-1:0] req;
    bypass_rsp_t [NP-1:0] rsp;
    bypass_req_t          breq;
    bypass_rsp_t          brsp;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          port;
        logic [63:0] rdata;
    } exp_t;
    exp_t exp_q[$];
    int   vcnt[NP];

    typedef struct {
        int          port;
        logic        we;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          gnt_dly;
        int          vld_dly;
        logic [63:0] rdata;
    } vec_t;
    vec_t vecs[5];

    std_cache_bypass_arbiter #(.NR_PORTS(NP)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .rsp_o        (rsp),
        .bypass_req_o (breq),
        .bypass_rsp_i (brsp),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [NP-1:0] gnt_vec();
        logic [NP-1:0] v;
        for (int i = 0; i < NP; i++) v[i] = rsp[i].gnt;
        return v;
    endfunction

    function automatic logic [NP-1:0] valid_vec();
        logic [NP-1:0] v;
        for (int i = 0; i < NP; i++) v[i] = rsp[i].valid;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every client valid must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int i = 0; i < NP; i++) begin
            if (rsp[i].valid === 1'b1) begin
                vcnt[i]++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL valid_unexpected port=%0d actual=1 required=0", i);
                end else begin
                    e = exp_q.pop_front();
                    if (e.port != i || rsp[i].rdata !== e.rdata) begin
                        bad++;
                        $display("FAIL valid_route actual port=%0d rdata=%h required port=%0d rdata=%h",
                                 i, rsp[i].rdata, e.port, e.rdata);
                    end
                end
            end
        end
    end

    task automatic chk_issue(input vec_t v);
        chk("issue_req",   64'(breq.req),   64'd1);
        chk("issue_id",    64'(breq.id),    64'(v.port));
        chk("issue_addr",  breq.addr,       v.addr);
        chk("issue_we",    64'(breq.we),    64'(v.we));
        chk("issue_be",    64'(breq.be),    64'(v.be));
        chk("issue_wdata", breq.wdata,      v.wdata);
        chk("issue_busy",  64'(busy),       64'd1);
    endtask

    // Called aligned at posedge+1; returns aligned at posedge+1.
    task automatic run_txn(input vec_t v);
        bypass_req_t r;
        r       = '0;
        r.req   = 1'b1;
        r.we    = v.we;
        r.be    = v.be;
        r.size  = 2'd3;
        r.id    = 4'hF;
        r.addr  = v.addr;
        r.wdata = v.wdata;
        req[v.port] = r;
        exp_q.push_back('{v.port, v.rdata});
        cyc();
        for (int g = 0; g < v.gnt_dly; g++) begin
            @(negedge clk);
            chk_issue(v);
            chk("stall_no_gnt", 64'(gnt_vec()), 64'd0);
            cyc();
        end
        brsp.gnt   = 1'b1;
        brsp.valid = (v.vld_dly == 0);
        brsp.rdata = v.rdata;
        @(negedge clk);
        chk_issue(v);
        chk("gnt_route", 64'(gnt_vec()), 64'(1) << v.port);
        cyc();
        req[v.port] = '0;
        brsp        = '0;
        if (v.vld_dly > 0) begin
            for (int k = 1; k < v.vld_dly; k++) begin
                @(negedge clk);
                chk("wait_req_low", 64'(breq.req), 64'd0);
                chk("wait_busy",    64'(busy),     64'd1);
                chk("wait_no_vld",  64'(valid_vec()), 64'd0);
                cyc();
            end
            brsp.valid = 1'b1;
            brsp.rdata = v.rdata;
            @(negedge clk);
            chk("vld_route", 64'(valid_vec()), 64'(1) << v.port);
            chk("vld_busy",  64'(busy),        64'd1);
            cyc();
            brsp = '0;
        end
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2, 1'b0, 8'hFF, 64'h8000_0010, 64'h0,    0, 2, 64'hDEAD_BEEF_0000_0001};
        vecs[1] = '{1, 1'b1, 8'h0F, 64'h8000_0100, 64'h1234, 5, 1, 64'h0};
        vecs[2] = '{0, 1'b0, 8'hFF, 64'h8000_0200, 64'h0,    0, 0, 64'h1111_2222_3333_4444};
        vecs[3] = '{3, 1'b0, 8'hF0, 64'h8000_0300, 64'h0,    2, 3, 64'h5555_6666_7777_8888};
        vecs[4] = '{2, 1'b1, 8'h01, 64'h8000_0400, 64'hAB,   1, 1, 64'h0};

        req  = '0;
        brsp = '0;
        foreach (vcnt[i]) vcnt[i] = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_breq_zero", 64'(breq == '0), 64'd1);
        chk("rst_busy",      64'(busy),        64'd0);
        chk("rst_gnt",       64'(gnt_vec()),   64'd0);
        chk("rst_valid",     64'(valid_vec()), 64'd0);
        chk("rst_rdata",     rsp[0].rdata,     64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        cyc();

        // All ports streaming with immediate gnt+valid: order 0,1,2,3,0,1,2,3
        for (int i = 0; i < NP; i++) begin
            req[i]      = '0;
            req[i].req  = 1'b1;
            req[i].addr = 64'h1000 * i;
            req[i].id   = 4'hA;
        end
        brsp.gnt   = 1'b1;
        brsp.valid = 1'b1;
        brsp.rdata = 64'hCAFE;
        foreach (vcnt[i]) vcnt[i] = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back('{i % NP, 64'hCAFE});
        for (int c = 0; c < 16; c++) begin
            cyc();
            @(negedge clk);
            if (c % 2 == 0) begin
                chk("rr_req",   64'(breq.req), 64'd1);
                chk("rr_order", 64'(breq.id),  64'((c / 2) % NP));
            end else begin
                chk("rr_gap",   64'(breq.req), 64'd0);
            end
        end
        req  = '0;
        brsp = '0;
        cyc();
        for (int i = 0; i < NP; i++) chk("rr_per_port", 64'(vcnt[i]), 64'd2);
        chk("rr_queue_empty", 64'(exp_q.size()), 64'd0);

        // Vector table of single transactions (last one leaves rr_ptr at 3)
        for (int n = 0; n < 5; n++) run_txn(vecs[n]);

        // Wrap: rr_ptr=3, ports 0 and 3 -> 3 wins, then 0
        req[0]      = '0;
        req[0].req  = 1'b1;
        req[0].addr = 64'h40;
        req[3]      = '0;
        req[3].req  = 1'b1;
        req[3].addr = 64'h43;
        exp_q.push_back('{3, 64'h33});
        exp_q.push_back('{0, 64'h44});
        cyc();
        brsp.gnt   = 1'b1;
        brsp.valid = 1'b1;
        brsp.rdata = 64'h33;
        @(negedge clk);
        chk("wrap_first_id",  64'(breq.id),    64'd3);
        chk("wrap_first_gnt", 64'(gnt_vec()),  64'h8);
        cyc();
        req[3] = '0;
        brsp   = '0;
        cyc();
        brsp.gnt   = 1'b1;
        brsp.valid = 1'b1;
        brsp.rdata = 64'h44;
        @(negedge clk);
        chk("wrap_second_id",   64'(breq.id),   64'd0);
        chk("wrap_second_addr", breq.addr,      64'h40);
        chk("wrap_second_gnt",  64'(gnt_vec()), 64'h1);
        cyc();
        req  = '0;
        brsp = '0;
        @(negedge clk);
        chk("wrap_idle", 64'(busy), 64'd0);
        cyc();

        // Protocol noise: valid in REQ without gnt, gnt in WAIT_RSP
        req[3]      = '0;
        req[3].req  = 1'b1;
        req[3].addr = 64'h600;
        exp_q.push_back('{3, 64'h66});
        cyc();
        brsp.valid = 1'b1;
        brsp.rdata = 64'h99;
        @(negedge clk);
        chk("noise_vld_ignored", 64'(valid_vec()), 64'd0);
        chk("noise_vld_no_gnt",  64'(gnt_vec()),   64'd0);
        cyc();
        brsp = '0;
        @(negedge clk);
        chk("noise_still_req",  64'(breq.req), 64'd1);
        chk("noise_still_busy", 64'(busy),     64'd1);
        cyc();
        brsp.gnt = 1'b1;
        @(negedge clk);
        chk("noise_gnt", 64'(gnt_vec()), 64'h8);
        cyc();
        req[3]   = '0;
        brsp.gnt = 1'b1;
        @(negedge clk);
        chk("noise_stray_gnt", 64'(gnt_vec()), 64'd0);
        chk("noise_wait_busy", 64'(busy),      64'd1);
        chk("noise_wait_req",  64'(breq.req),  64'd0);
        cyc();
        brsp.gnt   = 1'b0;
        brsp.valid = 1'b1;
        brsp.rdata = 64'h66;
        @(negedge clk);
        chk("noise_final_vld", 64'(valid_vec()), 64'h8);
        cyc();
        brsp = '0;
        @(negedge clk);
        chk("noise_idle", 64'(busy), 64'd0);
        cyc();

        // Reset in WAIT_RSP; late response must be dropped
        req[1]      = '0;
        req[1].req  = 1'b1;
        req[1].addr = 64'h700;
        exp_q.push_back('{1, 64'h77});
        cyc();
        brsp.gnt = 1'b1;
        @(negedge clk);
        chk("rst5_gnt", 64'(gnt_vec()), 64'h2);
        cyc();
        req[1] = '0;
        brsp   = '0;
        @(negedge clk);
        chk("rst5_wait_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("rst5_busy",  64'(busy),        64'd0);
        chk("rst5_breq",  64'(breq == '0),  64'd1);
        chk("rst5_valid", 64'(valid_vec()), 64'd0);
        cyc();
        rst_n      = 1'b1;
        brsp.valid = 1'b1;
        brsp.rdata = 64'h77;
        @(negedge clk);
        chk("rst5_late_drop", 64'(valid_vec()), 64'd0);
        chk("rst5_late_busy", 64'(busy),        64'd0);
        cyc();
        brsp = '0;
        run_txn('{0, 1'b0, 8'hFF, 64'h8000_0800, 64'h0, 0, 1, 64'h0808});
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
